// File: rtl/mir_pkg.sv
// Shared microinstruction field layout, templates, opcodes and step-count table
// for the stage-2 microsequencer.
package mir_pkg;

    localparam int unsigned UW_DEF = 34;

    // Field positions: BUSA|BUSB|BUSC|ALUC|SH|KMX|M|T (msb to lsb)
    localparam int unsigned BUSA_LSB = 30;
    localparam int unsigned BUSA_W   = 4;
    localparam int unsigned BUSB_LSB = 26;
    localparam int unsigned BUSB_W   = 4;
    localparam int unsigned BUSC_LSB = 22;
    localparam int unsigned BUSC_W   = 4;
    localparam int unsigned ALUC_LSB = 18;
    localparam int unsigned ALUC_W   = 4;
    localparam int unsigned SH_LSB   = 15;
    localparam int unsigned SH_W     = 3;
    localparam int unsigned KMX_LSB  = 13;
    localparam int unsigned KMX_W    = 2;
    localparam int unsigned M_LSB    = 12;
    localparam int unsigned T_LSB    = 0;
    localparam int unsigned T_W      = 12;
    localparam int unsigned OPC_W    = 4;

    typedef logic [UW_DEF-1:0] uinst_t;

    // Per-opcode (variable) part of a microinstruction
    typedef struct packed {
        logic [ALUC_W-1:0] aluc;
        logic [BUSB_W-1:0] busb;
        logic [T_W-1:0]    t;
    } uvar_t;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP  = 4'h0,
        OPC_MOV  = 4'h1,
        OPC_ADD  = 4'h2,
        OPC_ADDW = 4'h3,
        OPC_MAC3 = 4'h4,
        OPC_LONG = 4'h5
    } opc_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_e;

    localparam uvar_t NOP_V   = '{aluc: 4'h0, busb: 4'h0, t: 12'h000};
    localparam uvar_t MOV_V   = '{aluc: 4'h1, busb: 4'h0, t: 12'h001};
    localparam uvar_t ADD_V   = '{aluc: 4'h2, busb: 4'h3, t: 12'h002};
    localparam uvar_t ADDW1_V = '{aluc: 4'h1, busb: 4'h0, t: 12'h010};

    // Fixed fields shared by every microinstruction: BUSA=1, BUSC=2, SH=0, KMX=1, M=1
    localparam uinst_t FIX_U = (UW_DEF'(4'h1) << BUSA_LSB) |
                               (UW_DEF'(4'h2) << BUSC_LSB) |
                               (UW_DEF'(2'd1) << KMX_LSB)  |
                               (UW_DEF'(1'b1) << M_LSB);

    function automatic uinst_t compose(input uinst_t base, input uvar_t v);
        uinst_t u;
        u = base;
        u[ALUC_LSB +: ALUC_W] = v.aluc;
        u[BUSB_LSB +: BUSB_W] = v.busb;
        u[T_LSB +: T_W]       = v.t;
        return u;
    endfunction

    localparam uinst_t NOP_U   = compose(FIX_U, NOP_V);
    localparam uinst_t MOV_U   = compose(FIX_U, MOV_V);
    localparam uinst_t ADD_U   = compose(FIX_U, ADD_V);
    localparam uinst_t ADDW1_U = compose(FIX_U, ADDW1_V);

    // Nominal step count per opcode; LONG deliberately exceeds the sequencer depth
    function automatic int unsigned op_nsteps(input logic [OPC_W-1:0] opc);
        int unsigned n;
        n = 1;
        case (opc)
            OPC_ADDW: n = 2;
            OPC_MAC3: n = 3;
            OPC_LONG: n = 6;
            default:  n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mir_urom.sv
// Combinational micro-ROM: (opcode, step) -> variable fields, last-step and
// illegal flags. Steps beyond the sequencer depth are truncated and forced last.
module mir_urom
    import mir_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned SW        = 2
) (
    input  logic [OPC_W-1:0] i_opc,
    input  logic [SW-1:0]    i_step,
    output uvar_t            o_var,
    output logic             o_last,
    output logic             o_illegal
);

    int unsigned w_nsteps;
    int unsigned w_step_num;

    always_comb begin
        o_var      = NOP_V;
        o_illegal  = 1'b0;
        w_nsteps   = op_nsteps(i_opc);
        w_step_num = 32'(i_step) + 32'd1;
        case (i_opc)
            OPC_NOP:  o_var = NOP_V;
            OPC_MOV:  o_var = MOV_V;
            OPC_ADD:  o_var = ADD_V;
            OPC_ADDW: o_var = (i_step == '0) ? ADD_V : ADDW1_V;
            OPC_MAC3: o_var = '{aluc: 4'h3, busb: 4'd4 + 4'(i_step), t: 12'h100 + 12'(i_step)};
            OPC_LONG: o_var = '{aluc: 4'h5, busb: 4'(i_step), t: 12'h200 + 12'(i_step)};
            default:  o_illegal = 1'b1;
        endcase
        o_last = (w_step_num >= w_nsteps) || (w_step_num >= MAX_STEPS);
    end

endmodule

// File: rtl/mir_useq.sv
// Registered, handshaked microsequencer: decodes an opcode into 1..MAX_STEPS
// microinstructions with valid/ready flow control, stall and flush.
module mir_useq
    import mir_pkg::*;
#(
    parameter int unsigned IW        = 20,
    parameter int unsigned UW        = 34,
    parameter int unsigned OPC_LSB   = 12,
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned SW        = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [IW-1:0] INST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          FLUSH,
    output logic [UW-1:0] MICROINST,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [SW-1:0] OUT_STEP,
    output logic          OUT_LAST,
    output logic          ILLEGAL
);

    state_e             r_state;
    logic [OPC_W-1:0]   r_opc;
    logic [SW-1:0]      r_step;
    logic               r_out_valid;
    logic [UW-1:0]      r_uinst;
    logic [SW-1:0]      r_out_step;
    logic               r_out_last;
    logic               r_illegal;

    logic               w_busy;
    logic               w_adv;
    logic               w_accept;
    logic [OPC_W-1:0]   w_opc;
    logic [SW-1:0]      w_step;
    uvar_t              w_var;
    logic               w_last;
    logic               w_illegal;
    uinst_t             w_uinst;
    logic               w_unused_inst;

    assign w_busy   = (r_state == S_EXPAND);
    assign w_adv    = !r_out_valid || OUT_READY;
    assign IN_READY = w_adv && !w_busy && !FLUSH;
    assign w_accept = IN_VALID && IN_READY;

    // While expanding, decode the held opcode at the next step; otherwise step 0 of INST
    assign w_opc  = w_busy ? r_opc : INST[OPC_LSB +: OPC_W];
    assign w_step = w_busy ? (r_step + SW'(1)) : '0;

    assign w_unused_inst = ^INST;

    mir_urom #(
        .MAX_STEPS (MAX_STEPS),
        .SW        (SW)
    ) u_urom (
        .i_opc     (w_opc),
        .i_step    (w_step),
        .o_var     (w_var),
        .o_last    (w_last),
        .o_illegal (w_illegal)
    );

    assign w_uinst = compose(MOV_U, w_var);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_opc       <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_uinst     <= UW'(NOP_U);
            r_out_step  <= '0;
            r_out_last  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (FLUSH) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_uinst     <= UW'(NOP_U);
            r_out_step  <= '0;
            r_out_last  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_uinst     <= UW'(w_uinst);
                        r_out_step  <= '0;
                        r_out_last  <= w_last;
                        r_illegal   <= w_illegal;
                        r_step      <= '0;
                        if (!w_last) begin
                            r_opc   <= w_opc;
                            r_state <= S_EXPAND;
                        end
                    end else if (w_adv) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    if (w_adv) begin
                        r_out_valid <= 1'b1;
                        r_uinst     <= UW'(w_uinst);
                        r_out_step  <= w_step;
                        r_out_last  <= w_last;
                        r_illegal   <= w_illegal;
                        r_step      <= w_step;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MICROINST = r_uinst;
    assign OUT_VALID = r_out_valid;
    assign OUT_STEP  = r_out_step;
    assign OUT_LAST  = r_out_last;
    assign ILLEGAL   = r_illegal;

endmodule

// File: tb/tb_mir_useq.sv
// Directed self-checking bench for mir_useq: handshake, multi-step expansion,
// stall, flush, reset, illegal opcodes and an alternate opcode position.
module tb_mir_useq;

    // Hand-encoded microinstructions (BUSA=1,BUSC=2,KMX=1,M=1 in every word)
    localparam logic [33:0] E_NOP   = 34'h0_4080_3000;
    localparam logic [33:0] E_MOV   = 34'h0_4084_3001;
    localparam logic [33:0] E_ADD   = 34'h0_4C88_3002;
    localparam logic [33:0] E_ADDW1 = 34'h0_4084_3010;
    localparam logic [33:0] E_M0    = 34'h0_508C_3100;
    localparam logic [33:0] E_M1    = 34'h0_548C_3101;
    localparam logic [33:0] E_M2    = 34'h0_588C_3102;
    localparam logic [33:0] E_L0    = 34'h0_4094_3200;
    localparam logic [33:0] E_L1    = 34'h0_4494_3201;
    localparam logic [33:0] E_L2    = 34'h0_4894_3202;
    localparam logic [33:0] E_L3    = 34'h0_4C94_3203;

    logic        clk;
    logic        rst;
    logic [19:0] inst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [33:0] mi;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_step;
    logic        out_last;
    logic        illegal;

    logic [19:0] inst2;
    logic        in_valid2;
    logic        in_ready2;
    logic [33:0] mi2;
    logic        out_valid2;
    logic [1:0]  out_step2;
    logic        out_last2;
    logic        illegal2;

    int n_assert = 0;
    int n_fail   = 0;

    mir_useq u_dut (
        .CLK       (clk),
        .RESET     (rst),
        .INST      (inst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .FLUSH     (flush),
        .MICROINST (mi),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_STEP  (out_step),
        .OUT_LAST  (out_last),
        .ILLEGAL   (illegal)
    );

    mir_useq #(.OPC_LSB(16)) u_dut16 (
        .CLK       (clk),
        .RESET     (rst),
        .INST      (inst2),
        .IN_VALID  (in_valid2),
        .IN_READY  (in_ready2),
        .FLUSH     (1'b0),
        .MICROINST (mi2),
        .OUT_VALID (out_valid2),
        .OUT_READY (1'b1),
        .OUT_STEP  (out_step2),
        .OUT_LAST  (out_last2),
        .ILLEGAL   (illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [3:0] opc);
        return {4'h5, opc, 12'hA3C};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [33:0] u,
                              input logic [1:0] st, input logic last, input logic ill);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".uinst"}, 64'(mi), 64'(u));
        chk({tag, ".step"},  64'(out_step), 64'(st));
        chk({tag, ".last"},  64'(out_last), 64'(last));
        chk({tag, ".illegal"}, 64'(illegal), 64'(ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; inst = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst2 = '0; in_valid2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1 chk("reset.in_ready", 64'(in_ready), 64'd1);
        tick();
        expect_out("reset", 1'b0, E_NOP, 2'd0, 1'b0, 1'b0);

        // back-to-back single-step ops
        inst = mk(4'h1); in_valid = 1'b1;
        #1 chk("b2b.in_ready", 64'(in_ready), 64'd1);
        tick(); expect_out("b2b.mov0", 1'b1, E_MOV, 2'd0, 1'b1, 1'b0); inst = mk(4'h2);
        tick(); expect_out("b2b.add",  1'b1, E_ADD, 2'd0, 1'b1, 1'b0); inst = mk(4'h1);
        tick(); expect_out("b2b.mov1", 1'b1, E_MOV, 2'd0, 1'b1, 1'b0); in_valid = 1'b0;
        tick(); chk("b2b.drain", 64'(out_valid), 64'd0);

        // 3-step op with a MOV waiting behind it
        inst = mk(4'h4); in_valid = 1'b1;
        tick(); expect_out("mac.s0", 1'b1, E_M0, 2'd0, 1'b0, 1'b0); inst = mk(4'h1);
        #1 chk("mac.rdy0", 64'(in_ready), 64'd0);
        tick(); expect_out("mac.s1", 1'b1, E_M1, 2'd1, 1'b0, 1'b0);
        chk("mac.rdy1", 64'(in_ready), 64'd0);
        tick(); expect_out("mac.s2", 1'b1, E_M2, 2'd2, 1'b1, 1'b0);
        chk("mac.rdy2", 64'(in_ready), 64'd1);
        tick(); expect_out("mac.next", 1'b1, E_MOV, 2'd0, 1'b1, 1'b0); in_valid = 1'b0;
        tick(); chk("mac.drain", 64'(out_valid), 64'd0);

        // downstream stall on step 1
        inst = mk(4'h4); in_valid = 1'b1;
        tick(); expect_out("stall.s0", 1'b1, E_M0, 2'd0, 1'b0, 1'b0); in_valid = 1'b0;
        tick(); expect_out("stall.s1", 1'b1, E_M1, 2'd1, 1'b0, 1'b0); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("stall.hold", 1'b1, E_M1, 2'd1, 1'b0, 1'b0);
            chk("stall.rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick(); expect_out("stall.s2", 1'b1, E_M2, 2'd2, 1'b1, 1'b0);
        tick(); chk("stall.drain", 64'(out_valid), 64'd0);

        // flush during step 1 with a new instruction offered
        inst = mk(4'h4); in_valid = 1'b1;
        tick(); expect_out("flush.s0", 1'b1, E_M0, 2'd0, 1'b0, 1'b0); in_valid = 1'b0;
        tick(); expect_out("flush.s1", 1'b1, E_M1, 2'd1, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; inst = mk(4'h2);
        #1 chk("flush.rdy", 64'(in_ready), 64'd0);
        tick(); expect_out("flush.out", 1'b0, E_NOP, 2'd0, 1'b0, 1'b0);
        flush = 1'b0;
        #1 chk("flush.rdy_after", 64'(in_ready), 64'd1);
        tick(); expect_out("flush.add", 1'b1, E_ADD, 2'd0, 1'b1, 1'b0); in_valid = 1'b0;
        tick(); chk("flush.drain", 64'(out_valid), 64'd0);

        // undefined opcode then opcode 0
        inst = mk(4'hE); in_valid = 1'b1;
        tick(); expect_out("illegal.e", 1'b1, E_NOP, 2'd0, 1'b1, 1'b1); inst = mk(4'h0);
        tick(); expect_out("nop.0", 1'b1, E_NOP, 2'd0, 1'b1, 1'b0); in_valid = 1'b0;
        tick();

        // 2-step ADD-then-write
        inst = mk(4'h3); in_valid = 1'b1;
        tick(); expect_out("addw.s0", 1'b1, E_ADD, 2'd0, 1'b0, 1'b0); in_valid = 1'b0;
        tick(); expect_out("addw.s1", 1'b1, E_ADDW1, 2'd1, 1'b1, 1'b0);
        tick();

        // 6-step table entry truncated to 4 steps
        inst = mk(4'h5); in_valid = 1'b1;
        tick(); expect_out("long.s0", 1'b1, E_L0, 2'd0, 1'b0, 1'b0); in_valid = 1'b0;
        tick(); expect_out("long.s1", 1'b1, E_L1, 2'd1, 1'b0, 1'b0);
        tick(); expect_out("long.s2", 1'b1, E_L2, 2'd2, 1'b0, 1'b0);
        tick(); expect_out("long.s3", 1'b1, E_L3, 2'd3, 1'b1, 1'b0);
        chk("long.rdy", 64'(in_ready), 64'd1);
        tick(); chk("long.drain", 64'(out_valid), 64'd0);

        // reset in the middle of a 3-step expansion
        inst = mk(4'h4); in_valid = 1'b1;
        tick(); expect_out("rstmid.s0", 1'b1, E_M0, 2'd0, 1'b0, 1'b0); in_valid = 1'b0;
        tick(); expect_out("rstmid.s1", 1'b1, E_M1, 2'd1, 1'b0, 1'b0); rst = 1'b1;
        tick(); expect_out("rstmid.out", 1'b0, E_NOP, 2'd0, 1'b0, 1'b0); rst = 1'b0;
        #1 chk("rstmid.rdy", 64'(in_ready), 64'd1);

        // opcode at INST[19:16]; INST[15:12] holds a different opcode
        inst2 = {4'h2, 4'h1, 12'h000}; in_valid2 = 1'b1;
        #1 chk("lsb16.rdy", 64'(in_ready2), 64'd1);
        tick();
        chk("lsb16.add.valid", 64'(out_valid2), 64'd1);
        chk("lsb16.add.uinst", 64'(mi2), 64'(E_ADD));
        chk("lsb16.add.step", 64'(out_step2), 64'd0);
        chk("lsb16.add.last", 64'(out_last2), 64'd1);
        chk("lsb16.add.illegal", 64'(illegal2), 64'd0);
        inst2 = {4'hE, 4'h2, 12'h000};
        tick();
        chk("lsb16.ill.uinst", 64'(mi2), 64'(E_NOP));
        chk("lsb16.ill.illegal", 64'(illegal2), 64'd1);
        in_valid2 = 1'b0;
        tick();
        chk("lsb16.drain", 64'(out_valid2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mir_useq.md
Name: mir_useq

Overview:
- Registered, handshaked successor to the stage-2 microinstruction decoder.
- Decodes a parametrised opcode nybble from the fetched instruction word into a full microinstruction: fixed fields (BUSA, BUSC, SH, KMX, M) plus per-opcode ALUC, BUSB and T fields.
- Expands multi-step opcodes into 1..MAX_STEPS consecutive microinstructions.
- Sits between the instruction register and the datapath control stage; supports stall and flush.

Parameters:
- IW, 20, instruction word width.
- UW, 34, microinstruction width; field positions come from the shared microinstruction field constants.
- OPC_LSB, 12, LSB of the 4-bit opcode field in INST (opcode = INST[OPC_LSB+3:OPC_LSB]).
- MAX_STEPS, 4, maximum micro-steps per opcode (>=1).
- SW, $clog2(MAX_STEPS) (min 1), step index width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- INST  in  IW  instruction word.
- IN_VALID  in  1  INST valid.
- IN_READY  out  1  instruction accepted when IN_VALID && IN_READY.
- FLUSH  in  1  discard held instruction and output.
- MICROINST  out  UW  registered microinstruction.
- OUT_VALID  out  1  MICROINST valid.
- OUT_READY  in  1  downstream consumes when OUT_VALID && OUT_READY.
- OUT_STEP  out  SW  step index of MICROINST.
- OUT_LAST  out  1  MICROINST is final step of its instruction.
- ILLEGAL  out  1  MICROINST came from an undefined opcode.

Behaviour:
- Definitions:
  - adv = !OUT_VALID || OUT_READY.
  - busy = remaining steps > 0 for the held instruction (registers inst_q, step_q, nsteps_q).
- Reset (RESET=1 at edge):
  - OUT_VALID=0, MICROINST=NOP_U, OUT_STEP=0, OUT_LAST=0, ILLEGAL=0, busy=0.
  - RESET dominates FLUSH and all inputs.
- IN_READY = adv && !busy && !FLUSH. Combinational; no dependence on IN_VALID.
- Decode: sub-module mir_urom maps (opcode, step) to {ALUC, BUSB, T, last}. Fixed fields are always taken from the MOV template.
- Opcode 0 and undefined opcodes: one step, NOP fields. Undefined also sets ILLEGAL=1 on that output.
- States:
  - IDLE (busy=0):
    - On accept: register step-0 microinstruction, OUT_VALID=1, OUT_STEP=0.
    - If nsteps>1: capture INST, set busy; else stay IDLE.
    - If adv and no accept: OUT_VALID<=0.
  - EXPAND (busy=1):
    - On each adv: emit next step and increment step_q.
    - On emitting the step with last=1: busy<=0, OUT_LAST=1.
    - Next instruction can be accepted the cycle after the last step is loaded (IN_READY rises when busy clears).
- Stall: OUT_VALID && !OUT_READY holds MICROINST, OUT_STEP, OUT_LAST and ILLEGAL stable. No step advance.
- Latency: one cycle from accept to OUT_VALID. Throughput:
  - 1-step ops: one instruction per cycle with OUT_READY=1.
  - N-step ops: N cycles per instruction.
- FLUSH (synchronous):
  - Next cycle: OUT_VALID=0, MICROINST=NOP_U, busy=0, step_q=0.
  - Instruction presented with FLUSH is not accepted (IN_READY=0).
- Step counter never exceeds nsteps-1. A ROM entry with nsteps>MAX_STEPS is truncated at MAX_STEPS-1, and that step is forced last.
- Output changes only on adv, FLUSH or RESET.

Decomposition:
- Shared package mir_pkg holds:
  - microinstruction field bit positions;
  - template constants NOP_U, MOV_U, ADD_U and new multi-step templates (e.g. ADD-then-write: 2 steps);
  - opcode constants;
  - per-opcode step-count table.
- Sub-module mir_urom: combinational (opcode, step) -> {ALUC, BUSB, T, last, illegal}.
- mir_useq: handshake, step counter, output register.

Test Plan:
- Reset, then IN_VALID=0 -> OUT_VALID=0, MICROINST=NOP_U, IN_READY=1; RESET asserted mid-expansion of a 3-step op -> next cycle busy cleared, OUT_VALID=0.
- Back-to-back MOV, ADD, MOV with OUT_READY=1 -> three valid outputs on consecutive cycles, each OUT_STEP=0, OUT_LAST=1, fields match MOV_U/ADD_U/MOV_U.
- 3-step opcode, OUT_READY=1 -> OUT_STEP 0,1,2 on three cycles; OUT_LAST only on step 2; IN_READY low for 2 cycles, high on cycle of step 2.
- OUT_READY=0 for 4 cycles while OUT_VALID=1 on step 1 -> MICROINST/OUT_STEP=1 held stable; resumes with step 2 when OUT_READY=1.
- FLUSH during step 1 of 3-step op with IN_VALID=1 -> next cycle OUT_VALID=0, MICROINST=NOP_U, new instruction not accepted; accepted one cycle later.
- Opcode 4'hE (undefined) and opcode 0 -> one-step NOP fields; ILLEGAL=1 only for 4'hE; OPC_LSB=16 instance decodes from INST[19:16].
